group_quantizer: RTL and testbench



---
 rtl/group_quantizer_pkg.sv | 35 +++
 rtl/group_quantizer_if.sv | 45 ++++
 rtl/group_quantizer_divider.sv | 84 ++++++++
 rtl/group_quantizer.sv | 166 ++++++++++++++++
 tb/tb_group_quantizer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/group_quantizer_pkg.sv
// group_quantizer_pkg
//   Constants and types shared by the weight quantizer and the fused
//   dequantizer datapath. Holds the INT4/INT8 widths, the 4-bit code limit,
//   the quantizer state encoding and the code saturation helper.
package group_quantizer_pkg;

  localparam int INT4_W   = 4;
  localparam int INT8_W   = 8;
  localparam int INT4_MAX = 15;

  // Divider operand width: the largest dividend is 255 + floor(15/2) = 262.
  localparam int QDIV_W = 9;

  typedef enum logic [1:0] {
    COLLECT,
    SCALE,
    DIVIDE,
    EMIT
  } gq_state_e;

  // Adds the zero-point offset to a raw quotient and clamps it to the
  // largest INT4 code.
  function automatic logic [INT4_W-1:0] saturate_code(
    input logic [QDIV_W-1:0] quot,
    input logic [INT4_W-1:0] offset
  );
    int sum;
    sum = int'(quot) + int'(offset);
    if (sum > INT4_MAX) begin
      return INT4_W'(INT4_MAX);
    end
    return INT4_W'(sum);
  endfunction

endpackage

// File: rtl/group_quantizer_if.sv
// group_quantizer_if
//   Streaming bus of the group quantizer.
//   Input side : valid_in / ready_in handshake carrying int8_in.
//   Output side: valid_out / ready_out handshake carrying int4_out together
//                with scale_out, offset_out and last_out (end of group).
//   Modports   : slave  - the quantizer itself
//                master - the producer/consumer around it
interface group_quantizer_if;
  import group_quantizer_pkg::*;

  logic              valid_in;
  logic              ready_in;
  logic [INT8_W-1:0] int8_in;
  logic              valid_out;
  logic              ready_out;
  logic [INT4_W-1:0] int4_out;
  logic [INT4_W-1:0] scale_out;
  logic [INT4_W-1:0] offset_out;
  logic              last_out;

  modport slave (
    input  valid_in,
    input  int8_in,
    input  ready_out,
    output ready_in,
    output valid_out,
    output int4_out,
    output scale_out,
    output offset_out,
    output last_out
  );

  modport master (
    output valid_in,
    output int8_in,
    output ready_out,
    input  ready_in,
    input  valid_out,
    input  int4_out,
    input  scale_out,
    input  offset_out,
    input  last_out
  );

endinterface

// File: rtl/group_quantizer_divider.sv
// quant_divider
//   9-bit by 4-bit sequential restoring divider, one quotient bit per cycle,
//   MSB first. The first quotient bit is resolved on the start edge directly
//   from the dividend/divisor inputs, so a full quotient takes exactly
//   QDIV_W cycles from start; done pulses for one cycle once it is complete.
//   Ports:
//     clk, rst  - clock, synchronous active-low reset
//     start     - load operands and resolve the first quotient bit
//     dividend  - 9-bit unsigned dividend
//     divisor   - 4-bit unsigned divisor, must be non-zero
//     busy      - remaining quotient bits are being produced
//     done      - one-cycle pulse, quotient is valid
//     quotient  - 9-bit quotient, held until the next start
module quant_divider
  import group_quantizer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [QDIV_W-1:0] dividend,
  input  logic [INT4_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [QDIV_W-1:0] quotient
);

  logic [INT4_W-1:0] rem_q;
  logic [INT4_W-1:0] divisor_q;
  logic [QDIV_W-1:0] dvd_q;
  logic [QDIV_W-1:0] quot_q;
  logic [3:0]        steps_q;

  logic [INT4_W-1:0] rem_src;
  logic [INT4_W-1:0] div_src;
  logic              bit_src;
  logic [INT4_W:0]   trial;
  logic              q_bit;
  logic [INT4_W-1:0] rem_next;

  // One restoring step. The partial remainder always stays below the
  // divisor, so it fits in four bits both before and after the subtract.
  always_comb begin
    rem_src  = start ? '0 : rem_q;
    div_src  = start ? divisor : divisor_q;
    bit_src  = start ? dividend[QDIV_W-1] : dvd_q[QDIV_W-1];
    trial    = {rem_src, bit_src};
    q_bit    = (trial >= {1'b0, div_src});
    rem_next = q_bit ? INT4_W'(trial - {1'b0, div_src}) : trial[INT4_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q     <= '0;
      divisor_q <= '0;
      dvd_q     <= '0;
      quot_q    <= '0;
      steps_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q     <= rem_next;
        divisor_q <= div_src;
        dvd_q     <= {dividend[QDIV_W-2:0], 1'b0};
        quot_q    <= {{(QDIV_W-1){1'b0}}, q_bit};
        steps_q   <= 4'(QDIV_W - 1);
        busy      <= 1'b1;
      end else if (busy) begin
        rem_q   <= rem_next;
        dvd_q   <= {dvd_q[QDIV_W-2:0], 1'b0};
        quot_q  <= {quot_q[QDIV_W-2:0], q_bit};
        steps_q <= steps_q - 4'd1;
        if (steps_q == 4'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quot_q;

endmodule

// File: rtl/group_quantizer.sv
// group_quantizer
//   Streaming INT8 -> INT4 weight quantizer. Buffers a group of GROUP_SIZE
//   unsigned bytes, picks the smallest 4-bit scale that covers the group
//   maximum over the code range 15-OFFSET, then divides every element
//   (rounded to nearest) by that scale and emits one code per element.
//   Ports:
//     clk  - clock
//     rst  - synchronous active-low reset
//     bus  - group_quantizer_if.slave: input handshake (valid_in/ready_in/
//            int8_in) and output handshake (valid_out/ready_out/int4_out,
//            scale_out, offset_out, last_out)
module group_quantizer
  import group_quantizer_pkg::*;
#(
  parameter int GROUP_SIZE = 8,
  parameter int OFFSET     = 0
)
(
  input  logic               clk,
  input  logic               rst,
  group_quantizer_if.slave   bus
);

  localparam int CNT_W = $clog2(GROUP_SIZE);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(GROUP_SIZE - 1);
  localparam int RANGE = INT4_MAX - OFFSET;

  gq_state_e state_q;
  gq_state_e state_d;

  logic [INT8_W-1:0] buffer [GROUP_SIZE];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  idx_q;
  logic [INT8_W-1:0] max_q;
  logic [INT4_W-1:0] scale_q;
  logic [INT4_W-1:0] int4_q;
  logic              valid_q;
  logic              last_q;

  logic              ready_in;
  logic              accept;
  logic              last_accept;
  logic              out_hs;
  logic              div_start;
  logic              form_code;
  logic [INT4_W-1:0] scale_calc;
  logic [INT4_W-1:0] div_divisor;
  logic [CNT_W-1:0]  div_idx;
  logic [QDIV_W-1:0] div_dividend;
  logic              div_busy;
  logic              div_done;
  logic [QDIV_W-1:0] div_quot;

  assign accept      = bus.valid_in && ready_in;
  assign last_accept = accept && (cnt_q == LAST_IDX);
  assign out_hs      = valid_q && bus.ready_out;

  // Smallest scale s with RANGE*s >= max; scanning downward lets the
  // smallest qualifying value win. 15 is the fallback for oversized groups.
  always_comb begin
    scale_calc = INT4_W'(INT4_MAX);
    for (int s = INT4_MAX; s >= 1; s--) begin
      if (RANGE * s >= int'(max_q)) begin
        scale_calc = INT4_W'(s);
      end
    end
  end

  // The divider starts on the SCALE exit edge (scale not yet registered,
  // element 0) or on a non-final output handshake (next element).
  always_comb begin
    div_divisor  = (state_q == SCALE) ? scale_calc : scale_q;
    div_idx      = (state_q == SCALE) ? '0 : idx_q + 1'b1;
    div_dividend = QDIV_W'(buffer[div_idx]) + QDIV_W'(div_divisor >> 1);
  end

  quant_divider u_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (last_accept) state_d = SCALE;
      SCALE:   state_d = DIVIDE;
      DIVIDE:  if (form_code) state_d = EMIT;
      EMIT:    if (out_hs) state_d = last_q ? COLLECT : DIVIDE;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    ready_in  = (state_q == COLLECT);
    div_start = (state_q == SCALE) || ((state_q == EMIT) && out_hs && !last_q);
    form_code = (state_q == DIVIDE) && div_done && !div_busy;
  end

  // Buffer contents need no reset: every entry is rewritten before the
  // next group reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      buffer[cnt_q] <= bus.int8_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      max_q   <= '0;
      scale_q <= '0;
      int4_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q <= cnt_q + 1'b1;
        if (bus.int8_in > max_q) begin
          max_q <= bus.int8_in;
        end
      end
      if (state_q == SCALE) begin
        scale_q <= scale_calc;
        idx_q   <= '0;
        cnt_q   <= '0;
        max_q   <= '0;
      end
      if (form_code) begin
        int4_q  <= saturate_code(div_quot, INT4_W'(OFFSET));
        valid_q <= 1'b1;
        last_q  <= (idx_q == LAST_IDX);
      end
      if (out_hs) begin
        valid_q <= 1'b0;
        if (last_q) begin
          last_q <= 1'b0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign bus.ready_in   = ready_in;
  assign bus.valid_out  = valid_q;
  assign bus.int4_out   = int4_q;
  assign bus.scale_out  = scale_q;
  assign bus.offset_out = INT4_W'(OFFSET);
  assign bus.last_out   = last_q;

endmodule

// File: tb/tb_group_quantizer.sv
// tb_group_quantizer
//   Self-checking bench for group_quantizer (GROUP_SIZE=8, OFFSET=0).
//   Directed groups come from a vector table; random groups are checked
//   against an arithmetic reference model of the quantization rules.
module tb_group_quantizer;

  localparam int GS  = 8;
  localparam int OFS = 0;

  typedef struct packed {
    logic [0:GS-1][7:0] data;
    logic [3:0]         exp_scale;
    logic [0:GS-1][3:0] exp_codes;
    logic [3:0]         stall_idx;
    logic [3:0]         stall_len;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst;
  int    n_vectors = 0;
  int    n_miscompares = 0;
  int    cycle = 0;
  int    last_hs_cycle = 0;
  string cur_test = "init";

  group_quantizer_if bus();

  group_quantizer #(.GROUP_SIZE(GS), .OFFSET(OFS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s.%s: actual %0d, expected %0d", cur_test, name, actual, expected);
    end
  endtask

  // Reference model: scale = ceil(max / (15-OFFSET)) clamped to 1..15,
  // code = round(x / scale) + OFFSET clamped to 15.
  function automatic void modelGroup(input logic [0:GS-1][7:0] d,
                                     output logic [3:0] s,
                                     output logic [0:GS-1][3:0] c);
    int mx, r, sc, q;
    mx = 0;
    for (int i = 0; i < GS; i++) if (int'(d[i]) > mx) mx = int'(d[i]);
    r  = 15 - OFS;
    sc = (mx + r - 1) / r;
    if (sc < 1)  sc = 1;
    if (sc > 15) sc = 15;
    s = 4'(sc);
    for (int i = 0; i < GS; i++) begin
      q = (int'(d[i]) + sc / 2) / sc + OFS;
      if (q > 15) q = 15;
      c[i] = 4'(q);
    end
  endfunction

  // Called at a negedge; returns at the negedge after the last handshake.
  task automatic applyStimulus(input logic [0:GS-1][7:0] data);
    for (int i = 0; i < GS; i++) begin
      int t;
      t = 0;
      bus.valid_in = 1'b1;
      bus.int8_in  = data[i];
      while (bus.ready_in !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        checkOutput("ready_in_timeout", 32'(bus.ready_in), 1);
        bus.valid_in = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.valid_in  = 1'b0;
    last_hs_cycle = cycle;
  endtask

  task automatic receiveGroup(input int n, input logic [3:0] exp_scale,
                              input logic [0:GS-1][3:0] exp_codes,
                              input int stall_idx, input int stall_len);
    int prev_cycle;
    bit prev_stalled;
    prev_cycle   = 0;
    prev_stalled = 1'b0;
    for (int i = 0; i < n; i++) begin
      int t;
      bit stall;
      stall = (i == stall_idx) && (stall_len > 0);
      if (i > 0) @(negedge clk);
      if (stall) bus.ready_out = 1'b0;
      t = 0;
      while (bus.valid_out !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        checkOutput("valid_out_timeout", 32'(bus.valid_out), 1);
        bus.ready_out = 1'b1;
        return;
      end
      if (i == 0) checkOutput("first_code_latency", cycle - last_hs_cycle, 10);
      else if (!prev_stalled) checkOutput("code_spacing", cycle - prev_cycle, 10);
      prev_cycle = cycle;
      checkOutput("int4_out", 32'(bus.int4_out), 32'(exp_codes[i]));
      checkOutput("scale_out", 32'(bus.scale_out), 32'(exp_scale));
      checkOutput("last_out", 32'(bus.last_out), (i == GS - 1) ? 1 : 0);
      checkOutput("offset_out", 32'(bus.offset_out), OFS);
      checkOutput("ready_in_busy", 32'(bus.ready_in), 0);
      if (stall) begin
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          checkOutput("stall_valid", 32'(bus.valid_out), 1);
          checkOutput("stall_int4", 32'(bus.int4_out), 32'(exp_codes[i]));
          checkOutput("stall_scale", 32'(bus.scale_out), 32'(exp_scale));
          checkOutput("stall_ready_in", 32'(bus.ready_in), 0);
        end
        bus.ready_out = 1'b1;
      end
      prev_stalled = stall;
    end
    if (n == GS) begin
      @(negedge clk);
      checkOutput("ready_in_reassert", 32'(bus.ready_in), 1);
      checkOutput("valid_out_drop", 32'(bus.valid_out), 0);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_ready_in", 32'(bus.ready_in), 1);
    checkOutput("rst_valid_out", 32'(bus.valid_out), 0);
    checkOutput("rst_int4_out", 32'(bus.int4_out), 0);
    checkOutput("rst_scale_out", 32'(bus.scale_out), 0);
    checkOutput("rst_last_out", 32'(bus.last_out), 0);
    checkOutput("rst_offset_out", 32'(bus.offset_out), OFS);
  endtask

  vec_t  vecs[5];
  string names[5] = '{"zeros", "ramp", "saturate", "identity", "backpressure"};
  logic [0:GS-1][7:0] ramp_data;
  logic [0:GS-1][3:0] ramp_codes;

  initial begin
    ramp_data  = {8'd0, 8'd15, 8'd30, 8'd45, 8'd60, 8'd75, 8'd90, 8'd105};
    ramp_codes = {4'd0, 4'd2, 4'd4, 4'd6, 4'd9, 4'd11, 4'd13, 4'd15};

    vecs[0] = '0;
    vecs[0].exp_scale = 4'd1;
    vecs[1] = '0;
    vecs[1].data = ramp_data;
    vecs[1].exp_scale = 4'd7;
    vecs[1].exp_codes = ramp_codes;
    vecs[2] = '0;
    vecs[2].data = {8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vecs[2].exp_scale = 4'd15;
    vecs[2].exp_codes = {4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    vecs[3] = '0;
    vecs[3].data = {8'd15, 8'd3, 8'd7, 8'd0, 8'd1, 8'd14, 8'd8, 8'd2};
    vecs[3].exp_scale = 4'd1;
    vecs[3].exp_codes = {4'd15, 4'd3, 4'd7, 4'd0, 4'd1, 4'd14, 4'd8, 4'd2};
    vecs[4] = vecs[1];
    vecs[4].stall_idx = 4'd2;
    vecs[4].stall_len = 4'd5;

    rst           = 1'b0;
    bus.valid_in  = 1'b0;
    bus.int8_in   = '0;
    bus.ready_out = 1'b1;
    repeat (3) @(negedge clk);
    cur_test = "reset";
    checkResetState();
    rst = 1'b1;
    @(negedge clk);
    checkResetState();

    for (int v = 0; v < 5; v++) begin
      cur_test = names[v];
      applyStimulus(vecs[v].data);
      receiveGroup(GS, vecs[v].exp_scale, vecs[v].exp_codes,
                   int'(vecs[v].stall_idx), int'(vecs[v].stall_len));
    end

    // Reset while element 4 is being divided, then a clean ramp group.
    cur_test = "reset_mid";
    applyStimulus(ramp_data);
    receiveGroup(4, 4'd7, ramp_codes, -1, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkResetState();
    rst = 1'b1;
    @(negedge clk);
    cur_test = "after_reset";
    applyStimulus(ramp_data);
    receiveGroup(GS, 4'd7, ramp_codes, -1, 0);

    for (int g = 0; g < 20; g++) begin
      logic [0:GS-1][7:0] d;
      logic [3:0]         s;
      logic [0:GS-1][3:0] c;
      int limit;
      limit = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) limit = 255;
      for (int i = 0; i < GS; i++) d[i] = 8'($urandom_range(0, limit));
      modelGroup(d, s, c);
      cur_test = $sformatf("random%0d", g);
      applyStimulus(d);
      receiveGroup(GS, s, c, $urandom_range(0, GS - 1), $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
